// File: rtl/irq_pkg.sv
// Shared sizes and FSM encoding for the interrupt capture stage.
package irq_pkg;
  localparam int N = 8;  // request lines
  localparam int W = 3;  // index width, log2(N)

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;
endpackage

// File: rtl/irq_capture_if.sv
// Request/grant bundle between the request source/consumer and irq_capture.
// Overflow signals exist only when IRQ_OVERFLOW_EN is defined.
interface irq_capture_if;
  import irq_pkg::*;

  logic         en;
  logic [N-1:0] req;
  logic [N-1:0] mask;
  logic         irq_ack;
  logic         irq_valid;
  logic [W-1:0] irq_id;
  logic [N-1:0] pending;
`ifdef IRQ_OVERFLOW_EN
  logic         ovf;
  logic         ovf_clr;

  modport master (output en, req, mask, irq_ack, ovf_clr,
                  input  irq_valid, irq_id, pending, ovf);
  modport slave  (input  en, req, mask, irq_ack, ovf_clr,
                  output irq_valid, irq_id, pending, ovf);
`else
  modport master (output en, req, mask, irq_ack,
                  input  irq_valid, irq_id, pending);
  modport slave  (input  en, req, mask, irq_ack,
                  output irq_valid, irq_id, pending);
`endif
endinterface

// File: rtl/irq_prio_sel.sv
// Combinational N-to-W selector: index of the highest set bit plus an any-set flag.
module irq_prio_sel
  import irq_pkg::*;
(
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic         any
);

  // Ascending scan so the last (highest) set bit wins.
  always_comb begin
    idx = '0;
    any = |vec;
    for (int i = 0; i < N; i++)
      if (vec[i]) idx = W'(i);
  end

endmodule

// File: rtl/irq_capture.sv
// Interrupt capture and arbitration: latches rising edges on req into a
// pending register and presents the highest unmasked pending line as a held
// index with a valid/ack handshake.
// Optional feature macro: IRQ_OVERFLOW_EN (sticky overflow flag + clear).
module irq_capture
  import irq_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  irq_capture_if.slave  bus
);

  logic [N-1:0] req_q;
  logic [N-1:0] pend;
  logic [N-1:0] rise;
  logic [N-1:0] clr;
  logic [N-1:0] cand;
  logic [W-1:0] sel_idx;
  logic         sel_any;
  logic         take_ack;
  state_t       state;
  logic         vld;
  logic [W-1:0] id;

  assign rise     = bus.req & ~req_q;
  assign take_ack = (state == HOLD) && bus.irq_ack;
  assign clr      = take_ack ? (N'(1) << id) : '0;
  assign cand     = pend & ~bus.mask;

  irq_prio_sel u_sel (
    .vec (cand),
    .idx (sel_idx),
    .any (sel_any)
  );

  // Edge capture; a new rise on the bit being acked keeps it pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q <= '0;
      pend  <= '0;
    end else begin
      req_q <= bus.req;
      pend  <= (pend & ~clr) | rise;
    end
  end

  // Grant FSM: index is frozen while held, whatever mask/en/edges do.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      vld   <= 1'b0;
      id    <= '0;
    end else begin
      case (state)
        IDLE: if (bus.en && sel_any) begin
          state <= HOLD;
          vld   <= 1'b1;
          id    <= sel_idx;
        end
        HOLD: if (bus.irq_ack) begin
          state <= IDLE;
          vld   <= 1'b0;
        end
        default: begin
          state <= IDLE;
          vld   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.irq_valid = vld;
  assign bus.irq_id    = id;
  assign bus.pending   = pend;

`ifdef IRQ_OVERFLOW_EN
  logic ovf_q;

  // Sticky overflow: a rise on a bit that stays pending; set beats clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        ovf_q <= 1'b0;
    else if (|(rise & pend & ~clr)) ovf_q <= 1'b1;
    else if (bus.ovf_clr)           ovf_q <= 1'b0;
  end

  assign bus.ovf = ovf_q;
`endif

endmodule

// File: tb/tb_irq_capture.sv
// Randomized + directed bench for irq_capture with a queue scoreboard.
module tb_irq_capture;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  irq_capture_if bus_if ();

  irq_capture dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  // Reference model state: pending as a plain bit array, grant as flag + index.
  bit [7:0] m_pend;
  bit [7:0] m_req_prev;
  bit       m_hold;
  int       m_id;
  bit       m_ovf;
  int       exp_q[$];
  bit       prev_v;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: evaluate the capture/grant rules once per clock edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pend = '0; m_req_prev = '0; m_hold = 0; m_id = 0; m_ovf = 0;
      exp_q.delete();
    end else begin
      bit [7:0] old_pend;
      int       clr_bit;
      old_pend = m_pend;
      clr_bit  = -1;
      if (m_hold) begin
        if (bus_if.irq_ack) begin
          clr_bit = m_id;
          m_hold  = 0;
        end
      end else if (bus_if.en) begin
        for (int i = 7; i >= 0; i--)
          if (old_pend[i] && !bus_if.mask[i]) begin
            m_hold = 1;
            m_id   = i;
            exp_q.push_back(i);
            break;
          end
      end
      for (int i = 0; i < 8; i++) begin
        bit r;
        r = bus_if.req[i] && !m_req_prev[i];
        if (r && old_pend[i] && i != clr_bit) m_ovf = 1;
        m_pend[i] = (old_pend[i] && i != clr_bit) || r;
      end
`ifdef IRQ_OVERFLOW_EN
      begin
        bit set_now;
        set_now = 0;
        for (int i = 0; i < 8; i++)
          if (bus_if.req[i] && !m_req_prev[i] && old_pend[i] && i != clr_bit) set_now = 1;
        if (!set_now && bus_if.ovf_clr) m_ovf = 0;
      end
`endif
      m_req_prev = bus_if.req;
    end
  end

  // Monitor: compare state every cycle, pop a grant on each new valid.
  always @(negedge clk) begin
    if (rst) prev_v = 0;
    else begin
      chk("irq_valid", int'(bus_if.irq_valid), int'(m_hold));
      chk("pending", int'(bus_if.pending), int'(m_pend));
`ifdef IRQ_OVERFLOW_EN
      chk("ovf", int'(bus_if.ovf), int'(m_ovf));
`endif
      if (bus_if.irq_valid && !prev_v) begin
        if (exp_q.size() == 0) chk("unexpected_grant", int'(bus_if.irq_id), -1);
        else chk("grant_id", int'(bus_if.irq_id), exp_q.pop_front());
      end
      prev_v = bus_if.irq_valid;
    end
  end

  task automatic cyc(input logic [7:0] r, input logic [7:0] m, input logic e,
                     input logic a, input logic oc, input int n);
    repeat (n) begin
      @(negedge clk);
      bus_if.req     = r;
      bus_if.mask    = m;
      bus_if.en      = e;
      bus_if.irq_ack = a;
`ifdef IRQ_OVERFLOW_EN
      bus_if.ovf_clr = oc;
`else
      if (oc) ;
`endif
    end
  endtask

  initial begin
    bus_if.req = '0; bus_if.mask = '0; bus_if.en = 1'b1; bus_if.irq_ack = 1'b0;
`ifdef IRQ_OVERFLOW_EN
    bus_if.ovf_clr = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("rst_valid", int'(bus_if.irq_valid), 0);
    chk("rst_id", int'(bus_if.irq_id), 0);
    chk("rst_pending", int'(bus_if.pending), 0);
    #2 rst = 1'b0;

    // Single line, then ack.
    cyc(8'h00, 8'h00, 1, 0, 0, 2);
    cyc(8'h01, 8'h00, 1, 0, 0, 1);
    cyc(8'h00, 8'h00, 1, 0, 0, 3);
    cyc(8'h00, 8'h00, 1, 1, 0, 1);
    cyc(8'h00, 8'h00, 1, 0, 0, 2);
    // Three lines at once: 7, 3, 0.
    cyc(8'h89, 8'h00, 1, 0, 0, 1);
    cyc(8'h00, 8'h00, 1, 1, 0, 8);
    cyc(8'h00, 8'h00, 1, 0, 0, 2);
    // Masked top line delivered after mask release.
    cyc(8'h82, 8'h80, 1, 0, 0, 1);
    cyc(8'h00, 8'h80, 1, 0, 0, 3);
    cyc(8'h00, 8'h80, 1, 1, 0, 1);
    cyc(8'h00, 8'h00, 1, 0, 0, 3);
    cyc(8'h00, 8'h00, 1, 1, 0, 1);
    cyc(8'h00, 8'h00, 1, 0, 0, 2);
    // Presentation disabled, capture continues.
    cyc(8'h10, 8'h00, 0, 0, 0, 1);
    cyc(8'h00, 8'h00, 0, 0, 0, 3);
    cyc(8'h00, 8'h00, 1, 0, 0, 2);
    cyc(8'h00, 8'h00, 1, 1, 0, 1);
    cyc(8'h00, 8'h00, 1, 0, 0, 2);
    // Rise on the held bit in the ack cycle re-pends it.
    cyc(8'h04, 8'h00, 1, 0, 0, 1);
    cyc(8'h00, 8'h00, 1, 0, 0, 2);
    cyc(8'h04, 8'h00, 1, 1, 0, 1);
    cyc(8'h00, 8'h00, 1, 0, 0, 3);
    cyc(8'h00, 8'h00, 1, 1, 0, 1);
    cyc(8'h00, 8'h00, 1, 0, 0, 2);
    // Duplicate edge on a pending line, then clear.
    cyc(8'h20, 8'h00, 0, 0, 0, 1);
    cyc(8'h00, 8'h00, 0, 0, 0, 1);
    cyc(8'h20, 8'h00, 0, 0, 0, 1);
    cyc(8'h00, 8'h00, 0, 0, 0, 3);
    cyc(8'h00, 8'h00, 0, 0, 1, 1);
    cyc(8'h00, 8'h00, 1, 0, 0, 3);
    cyc(8'h00, 8'h00, 1, 1, 0, 1);
    cyc(8'h00, 8'h00, 1, 0, 0, 2);
    // Async reset while holding a grant.
    cyc(8'h08, 8'h00, 1, 0, 0, 1);
    cyc(8'h00, 8'h00, 1, 0, 0, 3);
    @(negedge clk);
    chk("pre_rst_valid", int'(bus_if.irq_valid), 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", int'(bus_if.irq_valid), 0);
    chk("async_rst_pending", int'(bus_if.pending), 0);
    @(negedge clk);
    #2 rst = 1'b0;

    // Random traffic.
    for (int k = 0; k < 3000; k++) begin
      logic [7:0] r, m;
      r = ($urandom_range(0, 3) == 0) ? 8'($urandom) : (bus_if.req & 8'($urandom));
      m = ($urandom_range(0, 5) == 0) ? 8'($urandom) : bus_if.mask;
      cyc(r, m, ($urandom_range(0, 9) != 0), ($urandom_range(0, 1) == 1),
          ($urandom_range(0, 19) == 0), 1);
    end

    // Drain and confirm every predicted grant was seen.
    cyc(8'h00, 8'h00, 1, 1, 0, 40);
    chk("drain_queue_empty", exp_q.size(), 0);
    chk("drain_pending", int'(bus_if.pending), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
